seq_controle: RTL

- Multi-cycle sequencer for the 4-bit accumulator datapath (regs X, Y, Z plus adder/subtractor ULA).
- Owns the program counter and fetches {func, value} words from the synchronous program memory.
- Decodes each word into one cycle of register/ULA control codes.
- Start/busy/done handshake toward the testbench or host. Replaces the free-running counter plus combinational controller pair.

---
 rtl/seq_controle.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/seq_controle.sv
// seq_controle: multi-cycle sequencer for the 4-bit accumulator datapath.
// Owns the program counter, fetches {func, value} words from synchronous
// program memory, and issues one cycle of register/ULA control per word.
// Optional single-step mode is compiled in when SEQ_STEP_EN is defined.
module seq_controle #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned FUNC_W   = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic [FUNC_W-1:0] mem_func,
  input  logic [3:0]        mem_value,
  input  logic              y_zero,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        op_x,
  output logic [2:0]        op_y,
  output logic [1:0]        op_z,
  output logic              op_ula,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  localparam logic [FUNC_W-1:0] OP_LDX  = FUNC_W'(4'h1);
  localparam logic [FUNC_W-1:0] OP_ADD  = FUNC_W'(4'h2);
  localparam logic [FUNC_W-1:0] OP_SUB  = FUNC_W'(4'h3);
  localparam logic [FUNC_W-1:0] OP_CLRY = FUNC_W'(4'h4);
  localparam logic [FUNC_W-1:0] OP_SHRY = FUNC_W'(4'h5);
  localparam logic [FUNC_W-1:0] OP_SHLY = FUNC_W'(4'h6);
  localparam logic [FUNC_W-1:0] OP_MOVZ = FUNC_W'(4'h7);
  localparam logic [FUNC_W-1:0] OP_JMP  = FUNC_W'(4'h8);
  localparam logic [FUNC_W-1:0] OP_JZ   = FUNC_W'(4'h9);
  localparam logic [FUNC_W-1:0] OP_CLRX = FUNC_W'(4'hA);
  localparam logic [FUNC_W-1:0] OP_CLRZ = FUNC_W'(4'hB);
  localparam logic [FUNC_W-1:0] OP_HALT = FUNC_W'(4'hF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
`ifdef SEQ_STEP_EN
    S_PAUSE,
`endif
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc_q, pc_nxt;
  logic [FUNC_W-1:0]   ir_func;
  logic [3:0]          ir_value;
  logic [ADDR_W-1:0]   target;
  logic [ADDR_W-1:0]   pc_inc;

`ifndef SEQ_STEP_EN
  logic unused_step;
  assign unused_step = step;
`endif

  assign target = ADDR_W'(ir_value);
  assign pc_inc = pc_q + ADDR_W'(1);
  assign pc     = pc_q;

  // State, program counter and instruction latch (latched at end of DECODE)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pc_q     <= PC_INIT;
      ir_func  <= '0;
      ir_value <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      if (state == S_DECODE) begin
        ir_func  <= mem_func;
        ir_value <= mem_value;
      end
    end
  end

  // Next state and next pc; pc only moves on start acceptance and in EXEC
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
          pc_nxt    = PC_INIT;
        end
      end
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
`ifdef SEQ_STEP_EN
        state_nxt = S_PAUSE;
`else
        state_nxt = S_FETCH;
`endif
        case (ir_func)
          OP_JMP:  pc_nxt = target;
          OP_JZ:   pc_nxt = y_zero ? target : pc_inc;
          OP_HALT: state_nxt = S_DONE;
          default: pc_nxt = pc_inc;
        endcase
      end
`ifdef SEQ_STEP_EN
      S_PAUSE: begin
        if (step) state_nxt = S_FETCH;
      end
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control outputs decoded from registered state and latched word only
  always_comb begin
    op_x   = '0;
    op_y   = '0;
    op_z   = '0;
    op_ula = 1'b0;
    busy   = (state != S_IDLE);
    done   = (state == S_DONE);
    if (state == S_EXEC) begin
      case (ir_func)
        OP_LDX:  op_x = 2'b01;
        OP_ADD:  op_y = 3'b001;
        OP_SUB: begin
          op_y   = 3'b001;
          op_ula = 1'b1;
        end
        OP_CLRY: op_y = 3'b010;
        OP_SHRY: op_y = 3'b011;
        OP_SHLY: op_y = 3'b100;
        OP_MOVZ: op_z = 2'b01;
        OP_CLRX: op_x = 2'b10;
        OP_CLRZ: op_z = 2'b10;
        default: ;
      endcase
    end
  end

endmodule
